// File: rtl/linescanner_sensor_emulator_if.sv
// Capture-unit <-> linescanner sensor signal bundle.
// The capture side drives the control strobes and the sensor side drives status and pixel data.
interface linescanner_sensor_emulator_if;
  logic        rst_cvc;
  logic        rst_cds;
  logic        sample;
  logic        load_pulse;
  logic        end_adc;
  logic        lval;
  logic [7:0]  data;
  logic [15:0] line_count;
  logic        protocol_error;

  modport master (
    output rst_cvc, rst_cds, sample, load_pulse,
    input  end_adc, lval, data, line_count, protocol_error
  );

  modport slave (
    input  rst_cvc, rst_cds, sample, load_pulse,
    output end_adc, lval, data, line_count, protocol_error
  );
endinterface

// File: rtl/linescanner_sensor_emulator.sv
// Linescanner sensor emulator: emulated ADC conversion plus one-line deterministic pixel readout,
// all on pixel_clock, for loopback bring-up of the capture unit.
module linescanner_sensor_emulator #(
  parameter int unsigned NUM_PIXELS   = 1024,
  parameter int unsigned ADC_CLOCKS   = 20,
  parameter int unsigned LOAD_TO_LVAL = 2,
  parameter logic [7:0]  PIXEL_STEP   = 8'd1
) (
  input logic                          pixel_clock,
  input logic                          reset,
  linescanner_sensor_emulator_if.slave bus
);

  typedef enum logic {AdcIdle, AdcConvert} adc_state_e;
  typedef enum logic [1:0] {RoIdle, RoDelay, RoStream} ro_state_e;

  localparam logic [7:0]  AdcLast   = 8'(ADC_CLOCKS - 1);
  localparam logic [3:0]  DelayLast = 4'(LOAD_TO_LVAL - 1);
  localparam logic [15:0] PixLast   = 16'(NUM_PIXELS - 1);

  adc_state_e  adc_state_q, adc_state_d;
  ro_state_e   ro_state_q, ro_state_d;
  logic        rst_cvc_q, sample_q, load_q;
  logic        sample_hist_d, load_hist_d;
  logic [7:0]  adc_cnt_q, adc_cnt_d;
  logic [3:0]  delay_cnt_q, delay_cnt_d;
  logic [15:0] pixel_idx_q, pixel_idx_d;
  logic [7:0]  line_id_q, line_id_d;
  logic        line_pending_q, line_pending_d;
  logic [15:0] line_count_q, line_count_d;
  logic        perr_q, perr_d;
  logic        sample_rise, load_rise, cvc_fall, adc_done, err;
  logic [7:0]  pix_offset;

  assign sample_rise = bus.sample & ~sample_q;
  assign load_rise   = bus.load_pulse & ~load_q;
  assign cvc_fall    = rst_cvc_q & ~bus.rst_cvc;

  // Integration start only restarts edge history; it reseeds from the live pins.
  always_comb begin
    sample_hist_d = bus.sample;
    load_hist_d   = bus.load_pulse;
    if (cvc_fall) begin
      sample_hist_d = bus.sample;
      load_hist_d   = bus.load_pulse;
    end
  end

  always_comb begin
    adc_state_d    = adc_state_q;
    adc_cnt_d      = adc_cnt_q;
    ro_state_d     = ro_state_q;
    delay_cnt_d    = delay_cnt_q;
    pixel_idx_d    = pixel_idx_q;
    line_id_d      = line_id_q;
    adc_done       = 1'b0;
    err            = 1'b0;

    unique case (adc_state_q)
      AdcIdle: begin
        if (sample_rise) begin
          adc_state_d = AdcConvert;
          adc_cnt_d   = 8'd0;
          err         = bus.rst_cds;
        end
      end
      AdcConvert: begin
        if (sample_rise) err = 1'b1;
        if (adc_cnt_q == AdcLast) begin
          adc_done    = 1'b1;
          adc_state_d = AdcIdle;
        end else begin
          adc_cnt_d = adc_cnt_q + 8'd1;
        end
      end
      default: adc_state_d = AdcIdle;
    endcase

    line_count_d   = adc_done ? line_count_q + 16'd1 : line_count_q;
    line_pending_d = line_pending_q | adc_done;

    unique case (ro_state_q)
      RoIdle: begin
        if (load_rise) begin
          // A conversion finishing on this same edge counts as the pending line.
          if (line_pending_q || adc_done) begin
            ro_state_d     = RoDelay;
            delay_cnt_d    = 4'd0;
            line_id_d      = line_count_d[7:0];
            line_pending_d = 1'b0;
          end else begin
            err = 1'b1;
          end
        end
      end
      RoDelay: begin
        if (load_rise) err = 1'b1;
        if (delay_cnt_q == DelayLast) begin
          ro_state_d  = RoStream;
          pixel_idx_d = 16'd0;
        end else begin
          delay_cnt_d = delay_cnt_q + 4'd1;
        end
      end
      RoStream: begin
        if (load_rise) err = 1'b1;
        if (pixel_idx_q == PixLast) begin
          ro_state_d = RoIdle;
        end else begin
          pixel_idx_d = pixel_idx_q + 16'd1;
        end
      end
      default: ro_state_d = RoIdle;
    endcase

    perr_d = perr_q | err;
  end

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      rst_cvc_q      <= 1'b1;
      sample_q       <= 1'b0;
      load_q         <= 1'b0;
      adc_state_q    <= AdcIdle;
      adc_cnt_q      <= 8'd0;
      ro_state_q     <= RoIdle;
      delay_cnt_q    <= 4'd0;
      pixel_idx_q    <= 16'd0;
      line_id_q      <= 8'd0;
      line_pending_q <= 1'b0;
      line_count_q   <= 16'd0;
      perr_q         <= 1'b0;
    end else begin
      rst_cvc_q      <= bus.rst_cvc;
      sample_q       <= sample_hist_d;
      load_q         <= load_hist_d;
      adc_state_q    <= adc_state_d;
      adc_cnt_q      <= adc_cnt_d;
      ro_state_q     <= ro_state_d;
      delay_cnt_q    <= delay_cnt_d;
      pixel_idx_q    <= pixel_idx_d;
      line_id_q      <= line_id_d;
      line_pending_q <= line_pending_d;
      line_count_q   <= line_count_d;
      perr_q         <= perr_d;
    end
  end

  // Only the low byte of the index matters modulo 256.
  assign pix_offset = pixel_idx_q[7:0] * PIXEL_STEP;

  assign bus.end_adc        = (adc_state_q == AdcIdle);
  assign bus.lval           = (ro_state_q == RoStream);
  assign bus.data           = bus.lval ? line_id_q + pix_offset : 8'd0;
  assign bus.line_count     = line_count_q;
  assign bus.protocol_error = perr_q;

endmodule
